ddr3_wb_arbiter: RTL and testbench

Multi-port Wishbone front-end for the DDR3 controller. Arbitrates NUM_PORTS pipelined Wishbone masters onto the single controller Wishbone port (i_wb_* / o_wb_* of the DDR3 top level). Supports round-robin or fixed-priority arbitration, bounded bursts per grant, an outstanding-request limit, and bus abort. Sits between the system interconnect and the DDR3 top, in the controller clock domain.

---
 rtl/ddr3_wb_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ddr3_wb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wb_arbiter.sv
// ddr3_wb_arbiter
// Multi-port Wishbone front-end for the DDR3 controller. Arbitrates
// NUM_PORTS pipelined Wishbone masters onto the single controller port.
// Arbitration is round-robin (ARB_MODE=0) or fixed priority with the lowest
// index winning (ARB_MODE=1). Each grant is bounded by BURST_MAX accepted
// requests and by MAX_OUTSTANDING accepted-but-unacked requests.
//
// Handshake: a request transfers on a cycle where stb is high and stall is
// low (accept = o_wb_stb & ~i_wb_stall). Acks carry no backpressure and are
// returned to the granted port in the cycle they arrive.
//
// Ports:
//   i_controller_clk, i_rst          clock, synchronous active-high reset
//   i_p_cyc/stb/we/addr/data/sel/aux per-port master requests (port k at slice k)
//   o_p_stall, o_p_ack               per-port stall / ack
//   o_p_data, o_p_aux                shared read data / aux, valid with o_p_ack
//   o_wb_* / i_wb_*                  controller Wishbone port
//   o_grant                          one-hot current grant, zero when idle
//   o_dbg_state                      FSM state (0 IDLE, 1 GRANT, 2 DRAIN)
module ddr3_wb_arbiter #(
    parameter int  NUM_PORTS       = 4,
    parameter int  WB_ADDR_BITS    = 24,
    parameter int  WB_DATA_BITS    = 512,
    localparam int WB_SEL_BITS     = WB_DATA_BITS / 8,
    parameter int  AUX_WIDTH       = 4,
    parameter int  MAX_OUTSTANDING = 16,
    parameter int  BURST_MAX       = 8,
    parameter int  ARB_MODE        = 0
) (
    input  logic                              i_controller_clk,
    input  logic                              i_rst,
    input  logic [NUM_PORTS-1:0]              i_p_cyc,
    input  logic [NUM_PORTS-1:0]              i_p_stb,
    input  logic [NUM_PORTS-1:0]              i_p_we,
    input  logic [NUM_PORTS*WB_ADDR_BITS-1:0] i_p_addr,
    input  logic [NUM_PORTS*WB_DATA_BITS-1:0] i_p_data,
    input  logic [NUM_PORTS*WB_SEL_BITS-1:0]  i_p_sel,
    input  logic [NUM_PORTS*AUX_WIDTH-1:0]    i_p_aux,
    output logic [NUM_PORTS-1:0]              o_p_stall,
    output logic [NUM_PORTS-1:0]              o_p_ack,
    output logic [WB_DATA_BITS-1:0]           o_p_data,
    output logic [AUX_WIDTH-1:0]              o_p_aux,
    output logic                              o_wb_cyc,
    output logic                              o_wb_stb,
    output logic                              o_wb_we,
    output logic [WB_ADDR_BITS-1:0]           o_wb_addr,
    output logic [WB_DATA_BITS-1:0]           o_wb_data,
    output logic [WB_SEL_BITS-1:0]            o_wb_sel,
    output logic [AUX_WIDTH-1:0]              o_wb_aux,
    input  logic                              i_wb_stall,
    input  logic                              i_wb_ack,
    input  logic [WB_DATA_BITS-1:0]           i_wb_data,
    input  logic [AUX_WIDTH-1:0]              i_wb_aux,
    output logic [NUM_PORTS-1:0]              o_grant,
    output logic [1:0]                        o_dbg_state
);

    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BURST_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic [NUM_PORTS-1:0] req, gnt_oh;
    logic                 active, full, accept, ack_ok, other_req;
    logic                 g_cyc, g_stb, g_we;
    logic [WB_ADDR_BITS-1:0] g_addr;
    logic [WB_DATA_BITS-1:0] g_data;
    logic [WB_SEL_BITS-1:0]  g_sel;
    logic [AUX_WIDTH-1:0]    g_aux;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;

    assign req       = i_p_cyc & i_p_stb;
    assign active    = (state_q != S_IDLE);
    assign gnt_oh    = active ? (NUM_PORTS'(1) << gnt_q) : '0;
    assign other_req = |(req & ~(NUM_PORTS'(1) << gnt_q));
    assign full      = (out_q == OUT_W'(MAX_OUTSTANDING));

    // Select the granted port's request fields.
    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_addr = '0;
        g_data = '0;
        g_sel  = '0;
        g_aux  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_q == IDX_W'(k)) begin
                g_cyc  = i_p_cyc[k];
                g_stb  = i_p_stb[k];
                g_we   = i_p_we[k];
                g_addr = i_p_addr[k*WB_ADDR_BITS +: WB_ADDR_BITS];
                g_data = i_p_data[k*WB_DATA_BITS +: WB_DATA_BITS];
                g_sel  = i_p_sel[k*WB_SEL_BITS +: WB_SEL_BITS];
                g_aux  = i_p_aux[k*AUX_WIDTH +: AUX_WIDTH];
            end
        end
    end

    // Winner search: round-robin starts at the port after the last grant,
    // fixed priority starts at port 0.
    always_comb begin
        int cand;
        cand    = 0;
        win_idx = '0;
        win_any = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (ARB_MODE == 0) ? ((int'(last_q) + k) % NUM_PORTS) : (k - 1);
            if (!win_any && req[IDX_W'(cand)]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

    assign o_wb_cyc  = active & g_cyc;
    assign o_wb_stb  = (state_q == S_GRANT) & g_cyc & g_stb & ~full;
    assign o_wb_we   = active & g_we;
    assign o_wb_addr = g_addr;
    assign o_wb_data = g_data;
    assign o_wb_sel  = g_sel;
    assign o_wb_aux  = g_aux;

    assign accept = o_wb_stb & ~i_wb_stall;
    // Acks while idle belong to an aborted cycle and are dropped.
    assign ack_ok = active & i_wb_ack;

    assign o_p_stall   = (state_q == S_GRANT) ? (~gnt_oh | {NUM_PORTS{i_wb_stall | full}}) : '1;
    assign o_p_ack     = ack_ok ? gnt_oh : '0;
    assign o_p_data    = ack_ok ? i_wb_data : '0;
    assign o_p_aux     = ack_ok ? i_wb_aux : '0;
    assign o_grant     = gnt_oh;
    assign o_dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        out_d   = out_q;
        burst_d = burst_q;
        if (accept) begin
            out_d   = out_q + 1'b1;
            burst_d = burst_q + 1'b1;
        end
        if (ack_ok && (out_q != '0)) begin
            out_d = out_d - 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (win_any) begin
                    state_d = S_GRANT;
                    gnt_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            S_GRANT: begin
                if (!g_cyc) begin
                    state_d = S_IDLE;
                end else if (burst_d == BURST_W'(BURST_MAX)) begin
                    state_d = S_DRAIN;
                end else if (!g_stb && other_req) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last ack is seen, not a cycle later.
                if (!g_cyc || (out_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            out_d   = '0;
            burst_d = '0;
        end
    end

    always_ff @(posedge i_controller_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            out_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            out_q   <= out_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Bench for ddr3_wb_arbiter. Two instances share the master-side stimulus:
// index 0 is round-robin, index 1 is fixed priority. Each has its own
// controller-side stall/ack drive and its own reference model.
module tb_ddr3_wb_arbiter;
    localparam int NP   = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int XW   = 4;
    localparam int MAXO = 4;
    localparam int BMAX = 6;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NP-1:0]    p_cyc, p_stb, p_we;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_data;
    logic [NP*SW-1:0] p_sel;
    logic [NP*XW-1:0] p_aux;

    logic          wb_stall[2], wb_ack[2];
    logic [DW-1:0] wb_data[2];
    logic [XW-1:0] wb_aux[2];

    logic [NP-1:0] o_stall[2], o_ack[2], o_grant[2];
    logic [DW-1:0] o_pdata[2], o_data[2];
    logic [XW-1:0] o_paux[2], o_aux[2];
    logic          o_cyc[2], o_stb[2], o_we[2];
    logic [AW-1:0] o_addr[2];
    logic [SW-1:0] o_sel[2];
    logic [1:0]    o_dbg[2];

    ddr3_wb_arbiter #(.NUM_PORTS(NP), .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .AUX_WIDTH(XW),
                      .MAX_OUTSTANDING(MAXO), .BURST_MAX(BMAX), .ARB_MODE(0)) dut_rr (
        .i_controller_clk(clk), .i_rst(rst),
        .i_p_cyc(p_cyc), .i_p_stb(p_stb), .i_p_we(p_we), .i_p_addr(p_addr),
        .i_p_data(p_data), .i_p_sel(p_sel), .i_p_aux(p_aux),
        .o_p_stall(o_stall[0]), .o_p_ack(o_ack[0]), .o_p_data(o_pdata[0]), .o_p_aux(o_paux[0]),
        .o_wb_cyc(o_cyc[0]), .o_wb_stb(o_stb[0]), .o_wb_we(o_we[0]), .o_wb_addr(o_addr[0]),
        .o_wb_data(o_data[0]), .o_wb_sel(o_sel[0]), .o_wb_aux(o_aux[0]),
        .i_wb_stall(wb_stall[0]), .i_wb_ack(wb_ack[0]), .i_wb_data(wb_data[0]), .i_wb_aux(wb_aux[0]),
        .o_grant(o_grant[0]), .o_dbg_state(o_dbg[0])
    );

    ddr3_wb_arbiter #(.NUM_PORTS(NP), .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .AUX_WIDTH(XW),
                      .MAX_OUTSTANDING(MAXO), .BURST_MAX(BMAX), .ARB_MODE(1)) dut_fp (
        .i_controller_clk(clk), .i_rst(rst),
        .i_p_cyc(p_cyc), .i_p_stb(p_stb), .i_p_we(p_we), .i_p_addr(p_addr),
        .i_p_data(p_data), .i_p_sel(p_sel), .i_p_aux(p_aux),
        .o_p_stall(o_stall[1]), .o_p_ack(o_ack[1]), .o_p_data(o_pdata[1]), .o_p_aux(o_paux[1]),
        .o_wb_cyc(o_cyc[1]), .o_wb_stb(o_stb[1]), .o_wb_we(o_we[1]), .o_wb_addr(o_addr[1]),
        .o_wb_data(o_data[1]), .o_wb_sel(o_sel[1]), .o_wb_aux(o_aux[1]),
        .i_wb_stall(wb_stall[1]), .i_wb_ack(wb_ack[1]), .i_wb_data(wb_data[1]), .i_wb_aux(wb_aux[1]),
        .o_grant(o_grant[1]), .o_dbg_state(o_dbg[1])
    );

    int checks = 0;
    int errors = 0;

    // staged master-side inputs, applied on the next falling edge
    logic [NP-1:0] s_cyc, s_stb;
    logic          s_rst;
    int            stall_mode;  // 0 random, 1 never stall
    int            ack_mode;    // 0 random, 1 withhold, 2 ack whenever possible

    // reference model: granted port (-1 idle), draining flag,
    // outstanding count, accepts in this grant, last granted port
    int m_g[2], m_out[2], m_burst[2], m_last[2];
    bit m_drain[2];

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_g[i] = -1; m_out[i] = 0; m_burst[i] = 0; m_last[i] = NP - 1; m_drain[i] = 0;
        end
    endtask

    task automatic rand_ports(input logic [NP-1:0] mask, input bit hold);
        for (int k = 0; k < NP; k++) begin
            if (!mask[k]) begin
                s_cyc[k] = 1'b0;
                s_stb[k] = 1'b0;
            end else begin
                if (hold) s_cyc[k] = 1'b1;
                else if ($urandom_range(0, 39) == 0) s_cyc[k] = ~s_cyc[k];
                s_stb[k] = s_cyc[k] && ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    // One clock: drive on the falling edge, compare 1 ns later, advance model.
    task automatic step();
        logic [NP-1:0] e_grant, e_stall, e_ack, reqs;
        logic [DW-1:0] e_pdata;
        logic [XW-1:0] e_paux;
        logic          e_cyc, e_stb, full, acc, others;
        int            g, w, c;
        @(negedge clk);
        rst    = s_rst;
        p_cyc  = s_cyc;
        p_stb  = s_stb;
        p_we   = NP'($urandom);
        p_addr = {$urandom, $urandom};
        p_data = {$urandom, $urandom, $urandom, $urandom};
        p_sel  = 16'($urandom);
        p_aux  = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            g = m_g[i];
            wb_stall[i] = (stall_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            wb_data[i]  = $urandom;
            wb_aux[i]   = XW'($urandom);
            if (g < 0)
                wb_ack[i] = (ack_mode == 2) || (ack_mode == 0 && $urandom_range(0, 7) == 0);
            else if (!p_cyc[g] || m_out[i] == 0)
                wb_ack[i] = 1'b0;
            else
                wb_ack[i] = (ack_mode == 2) || (ack_mode == 0 && $urandom_range(0, 2) == 0);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            g = m_g[i];
            e_grant = '0; e_cyc = 1'b0; e_stb = 1'b0; e_stall = '1; e_ack = '0;
            e_pdata = '0; e_paux = '0; full = 1'b0;
            if (g >= 0) begin
                full    = (m_out[i] == MAXO);
                e_grant = NP'(1) << g;
                e_cyc   = p_cyc[g];
                e_stb   = !m_drain[i] && p_cyc[g] && p_stb[g] && !full;
                e_stall[g] = m_drain[i] || wb_stall[i] || full;
                if (wb_ack[i]) begin
                    e_ack   = e_grant;
                    e_pdata = wb_data[i];
                    e_paux  = wb_aux[i];
                end
            end
            chk("grant", i, 64'(o_grant[i]), 64'(e_grant));
            chk("wb_cyc", i, 64'(o_cyc[i]), 64'(e_cyc));
            chk("wb_stb", i, 64'(o_stb[i]), 64'(e_stb));
            chk("p_stall", i, 64'(o_stall[i]), 64'(e_stall));
            chk("p_ack", i, 64'(o_ack[i]), 64'(e_ack));
            chk("p_data", i, 64'(o_pdata[i]), 64'(e_pdata));
            chk("p_aux", i, 64'(o_paux[i]), 64'(e_paux));
            if (e_stb) begin
                chk("wb_we", i, 64'(o_we[i]), 64'(p_we[g]));
                chk("wb_addr", i, 64'(o_addr[i]), 64'(p_addr[g*AW +: AW]));
                chk("wb_data", i, 64'(o_data[i]), 64'(p_data[g*DW +: DW]));
                chk("wb_sel", i, 64'(o_sel[i]), 64'(p_sel[g*SW +: SW]));
                chk("wb_aux", i, 64'(o_aux[i]), 64'(p_aux[g*XW +: XW]));
            end
            // next-state of the model
            reqs = p_cyc & p_stb;
            if (rst) begin
                m_g[i] = -1; m_out[i] = 0; m_burst[i] = 0; m_last[i] = NP - 1; m_drain[i] = 0;
            end else if (g < 0) begin
                w = -1;
                for (int k = 1; k <= NP; k++) begin
                    c = (i == 0) ? (m_last[i] + k) % NP : k - 1;
                    if (w < 0 && reqs[c]) w = c;
                end
                if (w >= 0) begin
                    m_g[i] = w; m_last[i] = w; m_drain[i] = 0; m_out[i] = 0; m_burst[i] = 0;
                end
            end else if (!p_cyc[g]) begin
                m_g[i] = -1; m_out[i] = 0; m_burst[i] = 0; m_drain[i] = 0;
            end else begin
                acc    = e_stb && !wb_stall[i];
                others = |(reqs & ~(NP'(1) << g));
                m_out[i]   = m_out[i] + int'(acc) - int'(wb_ack[i]);
                m_burst[i] = m_burst[i] + int'(acc);
                if (m_drain[i]) begin
                    if (m_out[i] == 0) begin
                        m_g[i] = -1; m_burst[i] = 0; m_drain[i] = 0;
                    end
                end else if (m_burst[i] == BMAX || (!p_stb[g] && others)) begin
                    m_drain[i] = 1;
                end
            end
        end
    endtask

    logic [NP-1:0] prev_grant[2];
    int            acc_cnt[2], n_gr[2];

    initial begin
        rst = 1'b1; s_rst = 1'b1; s_cyc = '0; s_stb = '0;
        stall_mode = 1; ack_mode = 1;
        model_reset();
        @(posedge clk);
        repeat (3) step();
        s_rst = 1'b0;
        step();
        chk("rst_grant", 0, 64'(o_grant[0]), 64'h0);
        chk("rst_stall", 0, 64'(o_stall[0]), 64'hf);
        chk("rst_cyc", 0, 64'(o_cyc[0]), 64'h0);
        chk("rst_ack", 0, 64'(o_ack[0]), 64'h0);

        // port 0 alone, controller never stalls, acks withheld until full
        s_cyc = 4'b0001; s_stb = 4'b0001;
        step();
        chk("a_idle", 0, 64'(o_grant[0]), 64'h0);
        step();
        chk("a_grant", 0, 64'(o_grant[0]), 64'h1);
        chk("a_stb", 0, 64'(o_stb[0]), 64'h1);
        repeat (3) step();
        step();
        chk("a_full_stall", 0, 64'(o_stall[0]), 64'hf);
        chk("a_full_stb", 0, 64'(o_stb[0]), 64'h0);
        ack_mode = 2;
        step();
        chk("a_ack", 0, 64'(o_ack[0]), 64'h1);
        ack_mode = 1;
        step();
        chk("a_release_stall", 0, 64'(o_stall[0]), 64'he);
        chk("a_release_stb", 0, 64'(o_stb[0]), 64'h1);
        step();
        chk("a_full_again", 0, 64'(o_stall[0]), 64'hf);
        s_stb = 4'b0000; ack_mode = 2;
        repeat (4) step();
        s_cyc = 4'b0000;
        step();
        step();
        chk("a_end_idle", 0, 64'(o_grant[0]), 64'h0);

        // port 1 aborts with 3 outstanding; later acks are dropped
        s_cyc = 4'b0010; s_stb = 4'b0010; ack_mode = 1;
        step();
        step();
        chk("b_grant", 0, 64'(o_grant[0]), 64'h2);
        chk("b_grant", 1, 64'(o_grant[1]), 64'h2);
        repeat (2) step();
        s_cyc = 4'b0000; s_stb = 4'b0000;
        step();
        chk("b_abort_cyc", 0, 64'(o_cyc[0]), 64'h0);
        chk("b_abort_cyc", 1, 64'(o_cyc[1]), 64'h0);
        ack_mode = 2;
        repeat (3) begin
            step();
            chk("b_idle_grant", 0, 64'(o_grant[0]), 64'h0);
            chk("b_drop_ack", 0, 64'(o_ack[0]), 64'h0);
        end

        // random traffic on all ports
        stall_mode = 0; ack_mode = 0;
        repeat (1500) begin
            rand_ports(4'hf, 1'b0);
            step();
        end

        // ports 0 and 2 busy, reset mid-burst
        repeat (40) begin
            rand_ports(4'b0101, 1'b1);
            step();
        end
        s_rst = 1'b1;
        step();
        s_rst = 1'b0; s_cyc = 4'b0101; s_stb = 4'b0101; stall_mode = 1; ack_mode = 2;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("r_grant", i, 64'(o_grant[i]), 64'h0);
            chk("r_cyc", i, 64'(o_cyc[i]), 64'h0);
            chk("r_stall", i, 64'(o_stall[i]), 64'hf);
            chk("r_ack", i, 64'(o_ack[i]), 64'h0);
            prev_grant[i] = '0; acc_cnt[i] = 0; n_gr[i] = 0;
        end
        // continuous requests from ports 0 and 2: bursts of BMAX accepts,
        // round-robin alternates 0,2,0,2, fixed priority keeps port 0
        repeat (70) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (o_grant[i] != '0 && prev_grant[i] == '0) begin
                    chk("alt_grant", i, 64'(o_grant[i]),
                        (i == 0 && (n_gr[i] % 2) == 1) ? 64'h4 : 64'h1);
                    if (n_gr[i] > 0) chk("burst_len", i, 64'(acc_cnt[i]), 64'(BMAX));
                    n_gr[i]++;
                    acc_cnt[i] = 0;
                end
                if (o_stb[i] && !wb_stall[i]) acc_cnt[i]++;
                prev_grant[i] = o_grant[i];
            end
        end

        // random stb on ports 0 and 2, then everything random again
        stall_mode = 0; ack_mode = 0;
        repeat (1500) begin
            rand_ports(4'b0101, 1'b1);
            step();
        end
        repeat (1000) begin
            rand_ports(4'hf, 1'b0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
